// File: rtl/rename_regfile_if.sv
// Issue, commit, broadcast and operand-output signals of the rename register file.
// The master drives requests and the slave (the register file) returns operands.
interface rename_regfile_if #(
  parameter int XLEN  = 32,
  parameter int NREG  = 32,
  parameter int TAG_W = 4
);
  localparam int RW = $clog2(NREG);

  logic             flush;
  logic             iss0_vld, iss1_vld;
  logic [RW-1:0]    iss0_rs1, iss0_rs2, iss0_rd;
  logic [RW-1:0]    iss1_rs1, iss1_rs2, iss1_rd;
  logic             iss0_we, iss1_we;
  logic [TAG_W-1:0] iss0_tag, iss1_tag;
  logic             cm_vld;
  logic [RW-1:0]    cm_rd;
  logic [TAG_W-1:0] cm_tag;
  logic [XLEN-1:0]  cm_val;
  logic             bc0_vld, bc1_vld;
  logic [TAG_W-1:0] bc0_tag, bc1_tag;
  logic [XLEN-1:0]  bc0_val, bc1_val;
  logic             out0_vld, out1_vld;
  logic [XLEN-1:0]  out0_vj, out0_vk, out1_vj, out1_vk;
  logic [TAG_W-1:0] out0_qj, out0_qk, out0_qd;
  logic [TAG_W-1:0] out1_qj, out1_qk, out1_qd;

  modport master (
    output flush,
    output iss0_vld, iss0_rs1, iss0_rs2, iss0_rd, iss0_we, iss0_tag,
    output iss1_vld, iss1_rs1, iss1_rs2, iss1_rd, iss1_we, iss1_tag,
    output cm_vld, cm_rd, cm_tag, cm_val,
    output bc0_vld, bc0_tag, bc0_val, bc1_vld, bc1_tag, bc1_val,
    input  out0_vld, out0_vj, out0_vk, out0_qj, out0_qk, out0_qd,
    input  out1_vld, out1_vj, out1_vk, out1_qj, out1_qk, out1_qd
  );

  modport slave (
    input  flush,
    input  iss0_vld, iss0_rs1, iss0_rs2, iss0_rd, iss0_we, iss0_tag,
    input  iss1_vld, iss1_rs1, iss1_rs2, iss1_rd, iss1_we, iss1_tag,
    input  cm_vld, cm_rd, cm_tag, cm_val,
    input  bc0_vld, bc0_tag, bc0_val, bc1_vld, bc1_tag, bc1_val,
    output out0_vld, out0_vj, out0_vk, out0_qj, out0_qk, out0_qd,
    output out1_vld, out1_vj, out1_vk, out1_qj, out1_qk, out1_qd
  );
endinterface

// File: rtl/rename_regfile.sv
// Two-wide rename register file: architectural values plus pending ROB tags,
// with same-cycle commit/broadcast forwarding and slot0->slot1 dependency bypass.
module rename_regfile #(
  parameter int XLEN  = 32,
  parameter int NREG  = 32,
  parameter int TAG_W = 4
) (
  input  logic           clk,
  input  logic           rst,
  rename_regfile_if.slave rf
);
  localparam int RW = $clog2(NREG);
  localparam int OW = TAG_W + XLEN;

  logic [XLEN-1:0]  regs [NREG];
  logic [TAG_W-1:0] q    [NREG];

  logic [OW-1:0] op0j_p0, op0k_p0, op1j_p0, op1k_p0;
  logic          ren0, ren1, cm_clr;

  // Returns {tag, value}; a pending tag resolves if commit or a bus carries it now.
  function automatic logic [OW-1:0] lookup(input logic [RW-1:0] rs);
    logic [TAG_W-1:0] qr;
    qr = q[rs];
    if (rs == '0)
      return '0;
    if (qr == '0)
      return {{TAG_W{1'b0}}, regs[rs]};
    if (rf.cm_vld && rf.cm_tag == qr)
      return {{TAG_W{1'b0}}, rf.cm_val};
    if (rf.bc0_vld && rf.bc0_tag == qr)
      return {{TAG_W{1'b0}}, rf.bc0_val};
    if (rf.bc1_vld && rf.bc1_tag == qr)
      return {{TAG_W{1'b0}}, rf.bc1_val};
    return {qr, {XLEN{1'b0}}};
  endfunction

  // Slot1 depends on slot0's destination: wait on slot0's tag.
  function automatic logic [OW-1:0] slot0_bypass(input logic [RW-1:0] rs,
                                                 input logic [OW-1:0] base);
    if (rf.iss0_vld && rf.iss0_we && rf.iss0_rd != '0 && rs == rf.iss0_rd)
      return {rf.iss0_tag, {XLEN{1'b0}}};
    return base;
  endfunction

  // Stage p0: operand lookup and rename/commit decisions on pre-update state
  always_comb begin
    op0j_p0 = lookup(rf.iss0_rs1);
    op0k_p0 = lookup(rf.iss0_rs2);
    op1j_p0 = slot0_bypass(rf.iss1_rs1, lookup(rf.iss1_rs1));
    op1k_p0 = slot0_bypass(rf.iss1_rs2, lookup(rf.iss1_rs2));
    ren0    = rf.iss0_vld && rf.iss0_we && rf.iss0_rd != '0 && !rf.flush;
    ren1    = rf.iss1_vld && rf.iss1_we && rf.iss1_rd != '0 && !rf.flush;
    cm_clr  = rf.cm_vld && rf.cm_rd != '0 && q[rf.cm_rd] == rf.cm_tag
              && !(ren0 && rf.iss0_rd == rf.cm_rd)
              && !(ren1 && rf.iss1_rd == rf.cm_rd);
  end

  // Stage p1: state update and registered operand outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
        q[i]    <= '0;
      end
      rf.out0_vld <= 1'b0;
      rf.out1_vld <= 1'b0;
      rf.out0_vj  <= '0;
      rf.out0_vk  <= '0;
      rf.out0_qj  <= '0;
      rf.out0_qk  <= '0;
      rf.out0_qd  <= '0;
      rf.out1_vj  <= '0;
      rf.out1_vk  <= '0;
      rf.out1_qj  <= '0;
      rf.out1_qk  <= '0;
      rf.out1_qd  <= '0;
    end else begin
      if (rf.cm_vld && rf.cm_rd != '0)
        regs[rf.cm_rd] <= rf.cm_val;
      if (rf.flush) begin
        for (int i = 0; i < NREG; i++)
          q[i] <= '0;
      end else begin
        if (cm_clr) q[rf.cm_rd]   <= '0;
        if (ren0)   q[rf.iss0_rd] <= rf.iss0_tag;
        if (ren1)   q[rf.iss1_rd] <= rf.iss1_tag;
      end
      rf.out0_vld <= rf.iss0_vld && !rf.flush;
      rf.out1_vld <= rf.iss1_vld && !rf.flush;
      {rf.out0_qj, rf.out0_vj} <= op0j_p0;
      {rf.out0_qk, rf.out0_vk} <= op0k_p0;
      {rf.out1_qj, rf.out1_vj} <= op1j_p0;
      {rf.out1_qk, rf.out1_vk} <= op1k_p0;
      rf.out0_qd <= rf.iss0_tag;
      rf.out1_qd <= rf.iss1_tag;
    end
  end
endmodule

// File: doc/rename_regfile.md
RENAME_REGFILE -- requirements
Module: rename_regfile

Interface
REQ-001 SHALL have parameter XLEN, default 32, data width.
REQ-002 SHALL have parameter NREG, default 32, architectural register count (power of 2); RW=log2(NREG).
REQ-003 SHALL have parameter TAG_W, default 4, ROB tag width; tag 0 = "no pending producer".
REQ-004 SHALL have port clk  in  1  clock, rising edge.
REQ-005 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-006 SHALL have port flush  in  1  mispredict flush, synchronous.
REQ-007 SHALL have ports issN_vld  in  1; issN_rs1, issN_rs2, issN_rd  in  RW; issN_we  in  1; issN_tag  in  TAG_W (N=0,1; slot1 younger than slot0).
REQ-008 SHALL have ports cm_vld  in  1; cm_rd  in  RW; cm_tag  in  TAG_W; cm_val  in  XLEN  (ROB commit).
REQ-009 SHALL have ports bcK_vld  in  1; bcK_tag  in  TAG_W; bcK_val  in  XLEN  (K=0 ALU CDB, K=1 load bus).
REQ-010 SHALL have outputs outN_vld  out  1; outN_vj, outN_vk  out  XLEN; outN_qj, outN_qk  out  TAG_W; outN_qd  out  TAG_W (N=0,1), all registered.

Function
REQ-011 SHALL hold regs[NREG] (XLEN) and q[NREG] (TAG_W); register 0 SHALL always read value 0, tag 0; writes/renames to 0 ignored.
REQ-012 Operand lookup for slot N, source rs SHALL use q[rs]/regs[rs] as of the current cycle (pre-update) and be presented on outputs the next cycle (latency 1).
REQ-013 If q[rs]!=0 and a same-cycle tag match exists, operand SHALL resolve to tag 0 with matching value; priority cm > bc0 > bc1.
REQ-014 Slot1 source equal to issue0 rd with iss0_vld & iss0_we & rd!=0 SHALL take q=iss0_tag, v=0, overriding REQ-012/013.
REQ-015 outN_vld SHALL pulse 1 cycle after issN_vld=1, otherwise 0; outN_qd SHALL equal issN_tag.
REQ-016 Rename: valid issue with we=1, rd!=0 SHALL set q[rd]<=tag; both slots same rd -> slot1 tag wins.
REQ-017 Commit: cm_vld SHALL write regs[cm_rd]<=cm_val (rd!=0); q[cm_rd] cleared to 0 only if q[cm_rd]==cm_tag and no same-cycle rename of cm_rd (rename wins).
REQ-018 Broadcast buses SHALL NOT modify regs or q; they only forward into same-cycle lookups.
REQ-019 flush SHALL clear all q to 0 and force out0_vld=out1_vld=0 next cycle; issue inputs ignored that cycle; regs preserved; cm in flush cycle SHALL still write regs.
REQ-020 Simultaneous cm and read of same register SHALL forward via REQ-013, never return stale regs value with tag 0.

Reset
REQ-021 rst SHALL zero all regs, all q, all outputs; rst overrides flush, commit and issue.
REQ-022 rst asserted mid-operation SHALL discard pending tags; first issue after rst sees all operands ready (q=0).

Verification
REQ-023 After rst, iss0: rs1=5, rs2=6, rd=7, tag=3 -> next cycle out0_vld=1, vj=vk=0, qj=qk=0, qd=3; q[7]=3.
REQ-024 q[7]=3, same cycle iss0 rs1=7 and bc1_vld tag=3 val=0xABCD -> out0_qj=0, vj=0xABCD; q[7] remains 3.
REQ-025 Dual issue: iss0 rd=8 tag=4, iss1 rs1=8 rd=8 tag=5 -> out1_qj=4; afterwards q[8]=5.
REQ-026 q[9]=6, cm rd=9 tag=2 val=0x55 -> regs[9]=0x55, q[9] stays 6; then cm rd=9 tag=6 val=0x77 -> q[9]=0, regs[9]=0x77.
REQ-027 q[10]=2, flush with cm rd=11 val=0x10 and iss0_vld=1 -> all q=0, out0_vld=0, regs[11]=0x10.
REQ-028 iss0 rd=0 tag=7, cm rd=0 val=0xFF -> q[0]=0, regs[0]=0; later read of x0 gives v=0, q=0.
